// File: rtl/mxint_quant_pkg.sv
// Shared constants, helpers and stage bundle for the MXINT quantizer.
// Exponent bias, mantissa limits, shift-width sizing, stage record.
package mxint_quant_pkg;

   localparam int MAX_EXP_W = 8;
   localparam int MAX_SH_W  = 8;

   function automatic int exp_bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

   function automatic int man_max(input int mw);
      return (1 << (mw - 1)) - 1;
   endfunction

   function automatic int man_min(input int mw);
      return -man_max(mw);
   endfunction

   // bits needed for a shift magnitude up to IN_WIDTH or OUT_MAN_WIDTH
   function automatic int shift_w(input int iw, input int mw);
      return $clog2(iw + mw);
   endfunction

   typedef struct packed {
      logic                       valid;
      logic [MAX_EXP_W-1:0]       exp;
      logic signed [MAX_SH_W-1:0] shift;
   } stage_t;

endpackage

// File: rtl/mxint_lod.sv
// Leading-one detector: index of the highest set bit of value.
// Ports: value (WIDTH) in; index, zero (value==0) out.
module mxint_lod #(
   parameter int WIDTH = 16,
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] value,
   output logic [IW-1:0]    index,
   output logic             zero
);

   always_comb begin
      index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) index = i[IW-1:0];
      end
      zero = ~|value;
   end

endmodule

// File: rtl/mxint_quantizer.sv
// Fixed-point to MXINT block quantizer, 3-stage valid/ready pipe.
// Ports: clk, rst, data_in/_valid/_ready, mdata_out, edata_out,
// data_out_valid/_ready; sat_count with MXINT_QUANT_STATS_EN.
module mxint_quantizer
   import mxint_quant_pkg::*;
#(
   parameter int IN_WIDTH      = 16,
   parameter int IN_FRAC_WIDTH = 8,
   parameter int BLOCK_SIZE    = 16,
   parameter int OUT_MAN_WIDTH = 8,
   parameter int OUT_EXP_WIDTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic [BLOCK_SIZE-1:0][IN_WIDTH-1:0] data_in,
   input  logic data_in_valid,
   output logic data_in_ready,
   output logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0] mdata_out,
   output logic [OUT_EXP_WIDTH-1:0] edata_out,
   output logic data_out_valid,
`ifdef MXINT_QUANT_STATS_EN
   output logic [31:0] sat_count,
`endif
   input  logic data_out_ready
);

   localparam int EB   = exp_bias(OUT_EXP_WIDTH);
   localparam int EMAX = (1 << OUT_EXP_WIDTH) - 1;
   localparam int IW   = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam int SH_W = shift_w(IN_WIDTH, OUT_MAN_WIDTH);
   localparam int AW   = IN_WIDTH + OUT_MAN_WIDTH + 2;
   localparam logic signed [AW-1:0] PMAX =
      AW'(man_max(OUT_MAN_WIDTH));
   localparam logic signed [AW-1:0] PMIN =
      AW'(man_min(OUT_MAN_WIDTH));

   logic   v1;
   stage_t s2;
   logic   v3;
   logic   r1, r2, r3;

   assign r3 = !v3 || data_out_ready;
   assign r2 = !s2.valid || r3;
   assign r1 = !v1 || r2;
   assign data_in_ready  = r1;
   assign data_out_valid = v3;

   // S1: register block and OR of magnitudes
   logic [BLOCK_SIZE-1:0][IN_WIDTH-1:0] s1_d;
   logic [IN_WIDTH-1:0] s1_or;
   logic [IN_WIDTH-1:0] or_n;

   // unsigned magnitude: -2^(IN_WIDTH-1) still fits
   always_comb begin
      or_n = '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         or_n = or_n | (data_in[i][IN_WIDTH-1] ?
                        (~data_in[i] + 1'b1) : data_in[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1    <= 1'b0;
         s1_d  <= '0;
         s1_or <= '0;
      end else if (r1) begin
         v1 <= data_in_valid;
         if (data_in_valid) begin
            s1_d  <= data_in;
            s1_or <= or_n;
         end
      end
   end

   // S2: shared exponent and shift
   logic [IW-1:0] lod_idx;
   logic          lod_zero;
   int            e_i, s_i;
   stage_t        s2_n;
   logic [BLOCK_SIZE-1:0][IN_WIDTH-1:0] s2_d;

   mxint_lod #(.WIDTH(IN_WIDTH)) u_lod (
      .value (s1_or),
      .index (lod_idx),
      .zero  (lod_zero)
   );

   // shift is clamped to the range where results still differ;
   // beyond it everything saturates or rounds to zero anyway
   always_comb begin
      e_i = int'(lod_idx) - IN_FRAC_WIDTH + 1 + EB;
      if (e_i < 0) e_i = 0;
      if (e_i > EMAX) e_i = EMAX;
      if (lod_zero) e_i = 0;
      s_i = e_i - EB + IN_FRAC_WIDTH - (OUT_MAN_WIDTH - 1);
      if (s_i < -OUT_MAN_WIDTH) s_i = -OUT_MAN_WIDTH;
      if (s_i > IN_WIDTH) s_i = IN_WIDTH;
      s2_n.valid = v1;
      s2_n.exp   = MAX_EXP_W'(e_i);
      s2_n.shift = MAX_SH_W'(s_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2   <= '0;
         s2_d <= '0;
      end else if (r2) begin
         s2.valid <= v1;
         if (v1) begin
            s2   <= s2_n;
            s2_d <= s1_d;
         end
      end
   end

   // S3: round/shift and saturate mantissas
   logic                neg;
   logic [SH_W-1:0]     amt;
   logic signed [AW-1:0] rnd, x_i, y_i;
   logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0] m_n;
`ifdef MXINT_QUANT_STATS_EN
   localparam int CW = $clog2(BLOCK_SIZE + 1);
   logic [BLOCK_SIZE-1:0] sat_n;
   logic [CW-1:0]         nsat_n, nsat;
`endif

   always_comb begin
      neg = s2.shift[MAX_SH_W-1];
      amt = SH_W'(neg ? -s2.shift : s2.shift);
      rnd = '0;
      if (!neg && amt != '0) rnd = AW'(1) <<< (amt - 1'b1);
      m_n = '0;
      x_i = '0;
      y_i = '0;
`ifdef MXINT_QUANT_STATS_EN
      sat_n  = '0;
      nsat_n = '0;
`endif
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         x_i = AW'(signed'(s2_d[i]));
         y_i = neg ? (x_i <<< amt) : ((x_i + rnd) >>> amt);
`ifdef MXINT_QUANT_STATS_EN
         sat_n[i] = (y_i > PMAX) || (y_i < PMIN);
         nsat_n   = nsat_n + CW'(sat_n[i]);
`endif
         if (y_i > PMAX) y_i = PMAX;
         else if (y_i < PMIN) y_i = PMIN;
         m_n[i] = y_i[OUT_MAN_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3        <= 1'b0;
         mdata_out <= '0;
         edata_out <= '0;
`ifdef MXINT_QUANT_STATS_EN
         nsat      <= '0;
`endif
      end else if (r3) begin
         v3 <= s2.valid;
         if (s2.valid) begin
            mdata_out <= m_n;
            edata_out <= OUT_EXP_WIDTH'(s2.exp);
`ifdef MXINT_QUANT_STATS_EN
            nsat      <= nsat_n;
`endif
         end
      end
   end

`ifdef MXINT_QUANT_STATS_EN
   logic [32:0] sat_sum;
   assign sat_sum = {1'b0, sat_count} + 33'(nsat);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sat_count <= '0;
      else if (v3 && data_out_ready)
         sat_count <= sat_sum[32] ? '1 : sat_sum[31:0];
   end
`endif

endmodule

// File: tb/tb_mxint_quantizer.sv
// Self-checking bench for mxint_quantizer: two instances
// (OUT_EXP_WIDTH 4 and 3), reference model and scoreboards.
module tb_mxint_quantizer;

   typedef logic [3:0][15:0] blk_t;
   typedef logic [3:0][7:0]  man_t;

   logic clk = 1'b0;
   logic rst;
   blk_t din;
   logic in_valid, ordy;
   logic rdy_a, rdy_b, vld_a, vld_b;
   man_t m_a, m_b;
   logic [3:0] e_a;
   logic [2:0] e_b;
`ifdef MXINT_QUANT_STATS_EN
   logic [31:0] sc_a, sc_b;
   longint exp_sa = 0, exp_sb = 0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mxint_quantizer #(
      .IN_WIDTH(16), .IN_FRAC_WIDTH(8), .BLOCK_SIZE(4),
      .OUT_MAN_WIDTH(8), .OUT_EXP_WIDTH(4)
   ) dut_a (
      .clk(clk), .rst(rst), .data_in(din),
      .data_in_valid(in_valid), .data_in_ready(rdy_a),
      .mdata_out(m_a), .edata_out(e_a),
      .data_out_valid(vld_a),
`ifdef MXINT_QUANT_STATS_EN
      .sat_count(sc_a),
`endif
      .data_out_ready(ordy)
   );

   mxint_quantizer #(
      .IN_WIDTH(16), .IN_FRAC_WIDTH(8), .BLOCK_SIZE(4),
      .OUT_MAN_WIDTH(8), .OUT_EXP_WIDTH(3)
   ) dut_b (
      .clk(clk), .rst(rst), .data_in(din),
      .data_in_valid(in_valid), .data_in_ready(rdy_b),
      .mdata_out(m_b), .edata_out(e_b),
      .data_out_valid(vld_b),
`ifdef MXINT_QUANT_STATS_EN
      .sat_count(sc_b),
`endif
      .data_out_ready(ordy)
   );

   task automatic chk(input string nm, input longint act,
                      input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic blk_t mkb(input int a, b, c, d);
      blk_t r;
      r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d);
      return r;
   endfunction

   function automatic man_t mkm(input int a, b, c, d);
      man_t r;
      r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
      return r;
   endfunction

   // reference: real = m/128 * 2^(e-bias); pick e from the block
   // magnitude, then scale each value with round-half-up
   function automatic void quant(input blk_t d, input int ew,
                                 output man_t m, output int e,
                                 output int ns);
      int bias, mo, lg, s, v, q;
      longint num, den;
      bias = (1 << (ew - 1)) - 1;
      mo = 0;
      m = '0; e = 0; ns = 0;
      for (int i = 0; i < 4; i++) begin
         v = int'(signed'(d[i]));
         mo = mo | (v < 0 ? -v : v);
      end
      if (mo == 0) return;
      lg = 0;
      while ((2 << lg) <= mo) lg++;
      e = lg - 8 + 1 + bias;
      if (e < 0) e = 0;
      if (e > (1 << ew) - 1) e = (1 << ew) - 1;
      s = e - bias + 8 - 7;
      for (int i = 0; i < 4; i++) begin
         v = int'(signed'(d[i]));
         if (s > 0) begin
            den = 64'(1) << s;
            num = longint'(v) + den / 2;
            q = int'(num / den);
            if ((num % den) != 0 && num < 0) q--;
         end else begin
            q = v * (1 << (-s));
         end
         if (q > 127) begin q = 127; ns++; end
         else if (q < -127) begin q = -127; ns++; end
         m[i] = 8'(q);
      end
   endfunction

   // scoreboard / compare process
   blk_t qa[$], qb[$];
   blk_t hb;
   man_t em, pm;
   int   ee, ns;
   logic hold = 1'b0;
   logic [3:0] pe;

   always @(negedge clk) begin
      if (rst) begin
         qa.delete(); qb.delete();
         hold = 1'b0;
`ifdef MXINT_QUANT_STATS_EN
         exp_sa = 0; exp_sb = 0;
         chk("rst sat a", longint'(sc_a), 0);
`endif
         chk("rst valid a", longint'(vld_a), 0);
         chk("rst valid b", longint'(vld_b), 0);
         chk("rst m a", longint'(m_a), 0);
         chk("rst e a", longint'(e_a), 0);
         chk("rst m b", longint'(m_b), 0);
         chk("rst e b", longint'(e_b), 0);
      end else begin
         if (hold) begin
            chk("hold valid", longint'(vld_a), 1);
            chk("hold m", longint'(m_a), longint'(pm));
            chk("hold e", longint'(e_a), longint'(pe));
         end
         hold = vld_a && !ordy;
         pm = m_a; pe = e_a;
`ifdef MXINT_QUANT_STATS_EN
         chk("sat_count a", longint'(sc_a), exp_sa);
         chk("sat_count b", longint'(sc_b), exp_sb);
`endif
         if (in_valid && rdy_a) qa.push_back(din);
         if (in_valid && rdy_b) qb.push_back(din);
         if (vld_a && ordy) begin
            if (qa.size() == 0) begin
               chk("unexpected out a", 1, 0);
            end else begin
               hb = qa.pop_front();
               quant(hb, 4, em, ee, ns);
               chk("sb m a", longint'(m_a), longint'(em));
               chk("sb e a", longint'(e_a), longint'(ee));
`ifdef MXINT_QUANT_STATS_EN
               exp_sa += ns;
`endif
            end
         end
         if (vld_b && ordy) begin
            if (qb.size() == 0) begin
               chk("unexpected out b", 1, 0);
            end else begin
               hb = qb.pop_front();
               quant(hb, 3, em, ee, ns);
               chk("sb m b", longint'(m_b), longint'(em));
               chk("sb e b", longint'(e_b), longint'(ee));
`ifdef MXINT_QUANT_STATS_EN
               exp_sb += ns;
`endif
            end
         end
      end
   end

   task automatic send(input blk_t d);
      int n;
      n = 0;
      din = d;
      in_valid = 1'b1;
      @(negedge clk);
      while (!rdy_a && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send accepted", longint'(rdy_a), 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic run_vec(input string nm, input blk_t d,
                          input man_t ma, input int ea,
                          input man_t mb, input int eb);
      int lat;
      send(d);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!vld_a && lat < 20);
      chk({nm, " latency"}, lat, 3);
      chk({nm, " m a"}, longint'(m_a), longint'(ma));
      chk({nm, " e a"}, longint'(e_a), ea);
      chk({nm, " m b"}, longint'(m_b), longint'(mb));
      chk({nm, " e b"}, longint'(e_b), eb);
      @(posedge clk);
      #1;
   endtask

   blk_t bp[6];
   man_t tm;
   int   te, tn, k, outs, cnt;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      din = '0;
      in_valid = 1'b0;
      ordy = 1'b1;

      quant(mkb(256, -128, 64, 0), 4, tm, te, tn);
      chk("model t1 m", longint'(tm), longint'(mkm(64, -32, 16, 0)));
      chk("model t1 e", te, 8);
      quant(mkb(255, 1, -3, 0), 4, tm, te, tn);
      chk("model t2 m", longint'(tm), longint'(mkm(127, 1, -1, 0)));
      chk("model t2 sat", tn, 1);
      quant(mkb(1, 0, 0, 0), 3, tm, te, tn);
      chk("model t3 m", longint'(tm), longint'(mkm(4, 0, 0, 0)));

      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready after reset", longint'(rdy_a), 1);
      chk("valid after reset", longint'(vld_a), 0);
      @(posedge clk);
      #1;

      run_vec("t1", mkb(256, -128, 64, 0),
              mkm(64, -32, 16, 0), 8, mkm(64, -32, 16, 0), 4);
      run_vec("t2a", mkb(3, 0, 0, 0),
              mkm(96, 0, 0, 0), 1, mkm(12, 0, 0, 0), 0);
      run_vec("t2b", mkb(255, 1, -3, 0),
              mkm(127, 1, -1, 0), 7, mkm(127, 1, -1, 0), 3);
      run_vec("t3a", mkb(1, 0, 0, 0),
              mkm(64, 0, 0, 0), 0, mkm(4, 0, 0, 0), 0);
      run_vec("t3b", mkb(32767, 0, 0, 0),
              mkm(127, 0, 0, 0), 14, mkm(127, 0, 0, 0), 7);
      run_vec("zero", mkb(0, 0, 0, 0),
              mkm(0, 0, 0, 0), 0, mkm(0, 0, 0, 0), 0);
      run_vec("neg", mkb(-32768, 5, 0, 7),
              mkm(-64, 0, 0, 0), 15, mkm(-127, 0, 0, 0), 7);

      // backpressure: 10 blocked cycles, then release
      bp[0] = mkb(100, -200, 300, -400);
      bp[1] = mkb(-32768, 5, 0, 7);
      bp[2] = mkb(1, 2, 3, 4);
      bp[3] = mkb(0, 0, 0, -1);
      bp[4] = mkb(12345, -12345, 77, -77);
      bp[5] = mkb(-1, -1, -1, -1);
      ordy = 1'b0;
      k = 0;
      repeat (10) begin
         din = bp[k];
         in_valid = 1'b1;
         @(negedge clk);
         if (rdy_a) k++;
         @(posedge clk);
         #1;
      end
      chk("bp accepted", k, 3);
      chk("bp ready low", longint'(rdy_a), 0);
      ordy = 1'b1;
      outs = 0;
      repeat (10) begin
         if (k < 6) begin
            din = bp[k];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (in_valid && rdy_a) k++;
         if (vld_a) outs++;
         @(posedge clk);
         #1;
      end
      chk("bp total accepted", k, 6);
      chk("bp outputs", outs, 6);
      chk("bp queue empty", qa.size(), 0);

      // reset with blocks in flight
      ordy = 1'b0;
      send(mkb(500, 1, 2, 3));
      send(mkb(-7, 9, 11, 0));
      @(posedge clk);
      #1;
      chk("pre-rst valid", longint'(vld_a), 1);
      #2 rst = 1'b1;
      #1;
      chk("async rst valid", longint'(vld_a), 0);
      chk("async rst m", longint'(m_a), 0);
      chk("async rst e", longint'(e_a), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      ordy = 1'b1;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (vld_a || vld_b) cnt++;
      end
      chk("no stale after rst", cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
